mux2_rr_arbiter: RTL and testbench
==================================

MUX2_RR_ARBITER -- requirements
Module: mux2_rr_arbiter

Interface
REQ-001 Parameter: WIDTH, 8, data width of each requester and of the output.
REQ-002 The block SHALL use one clock; reset is synchronous and active-high.
REQ-003 Port: clk  input  1  rising-edge clock for all state.
REQ-004 Port: rst  input  1  synchronous active-high reset.
REQ-005 Port: in_valid  input  2  per-requester beat valid; bit k belongs to requester k.
REQ-006 Port: in_last  input  2  per-requester end-of-packet marker, qualified by in_valid.
REQ-007 Port: in_data0 / in_data1  input  WIDTH each  requester payloads.
REQ-008 Port: in_ready  output  2  per-requester beat accept.
REQ-009 Port: out_valid / out_last  output  1 each  registered output beat valid and end-of-packet.
REQ-010 Port: out_data  output  WIDTH  registered selected payload.
REQ-011 Port: out_sel  output  1  index of the requester that sourced the current output beat.
REQ-012 Port: out_ready  input  1  downstream accept.
REQ-013 Port: busy  output  1  high while a packet grant is held.

Function
REQ-014 Two states SHALL exist: IDLE and BUSY. Internal regs: owner (1b), prio (1b).
REQ-015 In IDLE with any in_valid high, the block SHALL choose the winner and enter BUSY with owner=winner next cycle. No beat is accepted in the IDLE cycle.
- Both valid: winner = prio.
- One valid: that requester wins.
REQ-016 in_ready[k] SHALL equal (state==BUSY && owner==k && (!out_valid || out_ready)). in_ready[~owner] SHALL be 0.
REQ-017 A beat SHALL transfer when in_valid[owner] && in_ready[owner]. That edge loads out_data, out_last and out_sel=owner, and sets out_valid=1.
- Latency: 1 cycle from input transfer to out_valid.
REQ-018 out_valid SHALL clear on out_ready && out_valid unless a new beat is loaded in the same cycle.
- Simultaneous pop and push SHALL sustain 1 beat/cycle.
REQ-019 While out_valid && !out_ready, out_data, out_last and out_sel SHALL hold stable.
REQ-020 A transferred beat with in_last[owner]=1 SHALL return the FSM to IDLE and set prio=~owner on the same edge.
REQ-021 in_valid[owner] deasserting mid-packet SHALL keep BUSY and owner unchanged; no timeout exists.
REQ-022 Requests from the non-owner SHALL be ignored until IDLE. There SHALL be no preemption.
REQ-023 A single-beat packet (in_last=1 on first beat) SHALL occupy exactly 2 cycles of arbiter time: IDLE plus one BUSY cycle.
REQ-024 busy SHALL equal (state==BUSY).
REQ-025 Payload selection SHALL use owner as the mux select; in_data of the non-owner SHALL never reach out_data.

Reset
REQ-026 On rst=1 at a clock edge, the following SHALL take effect regardless of in-flight packets: state=IDLE, owner=0, prio=0, out_valid=0, out_last=0, out_sel=0, out_data=0, in_ready=00, busy=0.
REQ-027 A packet truncated by reset SHALL NOT resume. Arbitration restarts with requester 0 preferred.

Structure
REQ-028 Package mux_arb_pkg SHALL hold the state enum (IDLE, BUSY) and the default WIDTH constant.
REQ-029 Sub-module mux2_w SHALL implement the WIDTH-wide combinational 2:1 data select. FSM, handshake and output register SHALL stay in mux2_rr_arbiter.

Verification
REQ-030 Reset then in_valid=11, single-beat packets, out_ready=1 -> out_sel sequence 0,1,0,1; each out_valid pulse is 2 cycles after grant-start IDLE.
REQ-031 Requester 0 sends a 4-beat packet (data 0x10..0x13) while requester 1 is valid throughout -> out_data 0x10,0x11,0x12,0x13 with out_sel=0 and in_ready[1]=0 throughout; requester 1 is granted next.
REQ-032 out_ready held 0 for 3 cycles mid-packet -> out_data/out_last stable, in_ready[owner]=0; resumes with no beat lost or duplicated.
REQ-033 Owner drops in_valid for 2 cycles mid-packet -> busy stays 1, no other grant; packet completes on return.
REQ-034 rst asserted during beat 2 of a 4-beat packet -> next cycle all outputs at reset values; a new request from requester 1 alone is granted in IDLE.

Source files
------------

// File: rtl/mux_arb_pkg.sv
// Shared types and defaults for the two-requester packet arbiter.
package mux_arb_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

endpackage : mux_arb_pkg

// File: rtl/mux2_w.sv
// WIDTH-wide combinational 2:1 payload select.
module mux2_w
  import mux_arb_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y_c
);

  always_comb begin
    y_c = sel ? b : a;
  end

endmodule : mux2_w

// File: rtl/mux2_rr_arbiter.sv
// Packet-granular round-robin arbiter for two requesters with a registered
// single-entry output stage; the grant is held until the owner sends its last beat.
module mux2_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       in_valid,
  input  logic [1:0]       in_last,
  input  logic [WIDTH-1:0] in_data0,
  input  logic [WIDTH-1:0] in_data1,
  output logic [1:0]       in_ready,
  output logic             out_valid,
  output logic             out_last,
  output logic [WIDTH-1:0] out_data,
  output logic             out_sel,
  input  logic             out_ready,
  output logic             busy
);

  state_e           state_q, state_d;
  logic             owner_q, owner_d;
  logic             prio_q, prio_d;
  logic             out_valid_q, out_valid_d;
  logic             out_last_q, out_last_d;
  logic             out_sel_q, out_sel_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;

  logic             can_load_c;
  logic             xfer_c;
  logic [WIDTH-1:0] sel_data_c;

  // Owner drives the select so the non-owner payload can never be captured.
  mux2_w #(
    .WIDTH (WIDTH)
  ) u_mux (
    .sel (owner_q),
    .a   (in_data0),
    .b   (in_data1),
    .y_c (sel_data_c)
  );

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    prio_d      = prio_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_sel_d   = out_sel_q;
    out_data_d  = out_data_q;
    in_ready    = 2'b00;

    can_load_c = !out_valid_q || out_ready;
    xfer_c     = (state_q == BUSY) && in_valid[owner_q] && can_load_c;

    if ((state_q == BUSY) && can_load_c) begin
      in_ready[owner_q] = 1'b1;
    end

    case (state_q)
      IDLE: begin
        // Grant only; no beat is accepted in the arbitration cycle.
        if (|in_valid) begin
          state_d = BUSY;
          owner_d = (&in_valid) ? prio_q : in_valid[1];
        end
      end
      BUSY: begin
        if (xfer_c && in_last[owner_q]) begin
          state_d = IDLE;
          prio_d  = ~owner_q;
        end
      end
      default: state_d = IDLE;
    endcase

    // A load in the same cycle as a pop keeps out_valid set for 1 beat/cycle.
    if (xfer_c) begin
      out_valid_d = 1'b1;
      out_last_d  = in_last[owner_q];
      out_sel_d   = owner_q;
      out_data_d  = sel_data_c;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      prio_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_sel_q   <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      prio_q      <= prio_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_sel_q   <= out_sel_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_sel   = out_sel_q;
  assign out_data  = out_data_q;
  assign busy      = (state_q == BUSY);

endmodule : mux2_rr_arbiter

// File: tb/tb_mux2_rr_arbiter.sv
// Directed, table-driven bench for mux2_rr_arbiter plus hand-built stall,
// owner-drop and mid-packet reset sequences.
module tb_mux2_rr_arbiter;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst;
  logic [1:0]   in_valid;
  logic [1:0]   in_last;
  logic [W-1:0] in_data0;
  logic [W-1:0] in_data1;
  logic [1:0]   in_ready;
  logic         out_valid;
  logic         out_last;
  logic [W-1:0] out_data;
  logic         out_sel;
  logic         out_ready;
  logic         busy;

  mux2_rr_arbiter #(
    .WIDTH (W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_data0  (in_data0),
    .in_data1  (in_data1),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_last  (out_last),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         rst;
    logic [1:0]   iv;
    logic [1:0]   il;
    logic [W-1:0] d0;
    logic [W-1:0] d1;
    logic         ordy;
    logic         ov;
    logic         ol;
    logic [W-1:0] od;
    logic         os;
    logic [1:0]   ir;
    logic         bsy;
  } vec_t;

  vec_t tv[$];
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic vec_t mk(input logic r, input logic [1:0] iv, input logic [1:0] il,
                              input logic [W-1:0] d0, input logic [W-1:0] d1, input logic ordy,
                              input logic ov, input logic ol, input logic [W-1:0] od,
                              input logic os, input logic [1:0] ir, input logic bsy);
    vec_t v;
    v.rst = r;  v.iv = iv; v.il = il; v.d0 = d0; v.d1 = d1; v.ordy = ordy;
    v.ov  = ov; v.ol = ol; v.od = od; v.os = os; v.ir = ir; v.bsy = bsy;
    return v;
  endfunction

  // Inputs change on the falling edge; outputs are sampled 1 time unit later.
  task automatic drive(input logic r, input logic [1:0] iv, input logic [1:0] il,
                       input logic [W-1:0] d0, input logic [W-1:0] d1, input logic ordy);
    @(negedge clk);
    rst = r; in_valid = iv; in_last = il; in_data0 = d0; in_data1 = d1; out_ready = ordy;
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  logic [W-1:0] rx_data[$];
  logic         rx_last[$];
  logic         rx_sel[$];
  int           idx;
  logic         ordy;
  logic         v0;
  logic [W-1:0] d0;

  task automatic capture();
    if (out_valid && out_ready) begin
      rx_data.push_back(out_data);
      rx_last.push_back(out_last);
      rx_sel.push_back(out_sel);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 2'b00; in_last = 2'b00;
    in_data0 = '0; in_data1 = '0; out_ready = 1'b0;

    // Alternating single-beat packets, then a 4-beat packet with requester 1 waiting.
    tv.push_back(mk(1, 2'b00, 2'b00, 8'h00, 8'h00, 0,  0, 0, 8'h00, 0, 2'b00, 0));
    tv.push_back(mk(0, 2'b11, 2'b11, 8'hA0, 8'hB1, 1,  0, 0, 8'h00, 0, 2'b00, 0));
    tv.push_back(mk(0, 2'b11, 2'b11, 8'hA0, 8'hB1, 1,  0, 0, 8'h00, 0, 2'b01, 1));
    tv.push_back(mk(0, 2'b11, 2'b11, 8'hA0, 8'hB1, 1,  1, 1, 8'hA0, 0, 2'b00, 0));
    tv.push_back(mk(0, 2'b11, 2'b11, 8'hA0, 8'hB1, 1,  0, 1, 8'hA0, 0, 2'b10, 1));
    tv.push_back(mk(0, 2'b11, 2'b11, 8'hA0, 8'hB1, 1,  1, 1, 8'hB1, 1, 2'b00, 0));
    tv.push_back(mk(0, 2'b11, 2'b11, 8'hA0, 8'hB1, 1,  0, 1, 8'hB1, 1, 2'b01, 1));
    tv.push_back(mk(0, 2'b11, 2'b11, 8'hA0, 8'hB1, 1,  1, 1, 8'hA0, 0, 2'b00, 0));
    tv.push_back(mk(0, 2'b11, 2'b11, 8'hA0, 8'hB1, 1,  0, 1, 8'hA0, 0, 2'b10, 1));
    tv.push_back(mk(0, 2'b00, 2'b00, 8'hA0, 8'hB1, 1,  1, 1, 8'hB1, 1, 2'b00, 0));
    tv.push_back(mk(0, 2'b11, 2'b10, 8'h10, 8'h55, 1,  0, 1, 8'hB1, 1, 2'b00, 0));
    tv.push_back(mk(0, 2'b11, 2'b10, 8'h10, 8'h55, 1,  0, 1, 8'hB1, 1, 2'b01, 1));
    tv.push_back(mk(0, 2'b11, 2'b10, 8'h11, 8'h55, 1,  1, 0, 8'h10, 0, 2'b01, 1));
    tv.push_back(mk(0, 2'b11, 2'b10, 8'h12, 8'h55, 1,  1, 0, 8'h11, 0, 2'b01, 1));
    tv.push_back(mk(0, 2'b11, 2'b11, 8'h13, 8'h55, 1,  1, 0, 8'h12, 0, 2'b01, 1));
    tv.push_back(mk(0, 2'b10, 2'b10, 8'h13, 8'h55, 1,  1, 1, 8'h13, 0, 2'b00, 0));
    tv.push_back(mk(0, 2'b10, 2'b10, 8'h13, 8'h55, 1,  0, 1, 8'h13, 0, 2'b10, 1));
    tv.push_back(mk(0, 2'b00, 2'b00, 8'h13, 8'h55, 1,  1, 1, 8'h55, 1, 2'b00, 0));
    tv.push_back(mk(0, 2'b00, 2'b00, 8'h13, 8'h55, 1,  0, 1, 8'h55, 1, 2'b00, 0));

    for (int i = 0; i < tv.size(); i++) begin
      drive(tv[i].rst, tv[i].iv, tv[i].il, tv[i].d0, tv[i].d1, tv[i].ordy);
      chk($sformatf("v%0d out_valid", i), 32'(out_valid), 32'(tv[i].ov));
      chk($sformatf("v%0d out_last", i),  32'(out_last),  32'(tv[i].ol));
      chk($sformatf("v%0d out_data", i),  32'(out_data),  32'(tv[i].od));
      chk($sformatf("v%0d out_sel", i),   32'(out_sel),   32'(tv[i].os));
      chk($sformatf("v%0d in_ready", i),  32'(in_ready),  32'(tv[i].ir));
      chk($sformatf("v%0d busy", i),      32'(busy),      32'(tv[i].bsy));
    end

    // Downstream stall of 3 cycles in the middle of a 4-beat packet.
    drive(1, 2'b00, 2'b00, 8'h00, 8'h00, 1);
    rx_data.delete(); rx_last.delete(); rx_sel.delete();
    idx = 0;
    for (int c = 0; c < 20 && rx_data.size() < 4; c++) begin
      ordy = !(c >= 4 && c <= 6);
      d0   = 8'(32'h20 + idx);
      drive(0, {1'b0, idx < 4}, {1'b0, idx == 3}, d0, 8'h99, ordy);
      if (c >= 4 && c <= 6) begin
        chk($sformatf("stall c%0d out_valid", c), 32'(out_valid), 32'd1);
        chk($sformatf("stall c%0d out_data", c),  32'(out_data),  32'h22);
        chk($sformatf("stall c%0d out_last", c),  32'(out_last),  32'd0);
        chk($sformatf("stall c%0d in_ready", c),  32'(in_ready),  32'd0);
      end
      capture();
      if (in_ready[0] && in_valid[0]) idx++;
    end
    chk("stall beat count", 32'(rx_data.size()), 32'd4);
    for (int i = 0; i < rx_data.size(); i++) begin
      chk($sformatf("stall beat%0d data", i), 32'(rx_data[i]), 32'h20 + 32'(i));
      chk($sformatf("stall beat%0d last", i), 32'(rx_last[i]), 32'(i == 3));
    end

    // Owner drops in_valid for 2 cycles; requester 1 waits and is granted afterwards.
    drive(1, 2'b00, 2'b00, 8'h00, 8'h00, 1);
    rx_data.delete(); rx_last.delete(); rx_sel.delete();
    idx = 0;
    for (int c = 0; c < 20 && rx_data.size() < 4; c++) begin
      v0 = (idx < 3) && !(c == 2 || c == 3);
      d0 = 8'(32'h30 + idx);
      drive(0, {1'b1, v0}, {1'b1, idx == 2}, d0, 8'h55, 1);
      if (c == 2 || c == 3) begin
        chk($sformatf("drop c%0d busy", c),     32'(busy),     32'd1);
        chk($sformatf("drop c%0d in_ready", c), 32'(in_ready), 32'b01);
      end
      capture();
      if (in_ready[0] && in_valid[0]) idx++;
    end
    chk("drop beat count", 32'(rx_data.size()), 32'd4);
    for (int i = 0; i < rx_data.size(); i++) begin
      chk($sformatf("drop beat%0d data", i), 32'(rx_data[i]), (i < 3) ? 32'h30 + 32'(i) : 32'h55);
      chk($sformatf("drop beat%0d sel", i),  32'(rx_sel[i]),  32'(i == 3));
    end

    // Reset lands on beat 2 of a 4-beat packet; the packet must not resume.
    drive(1, 2'b00, 2'b00, 8'h00, 8'h00, 1);
    drive(0, 2'b01, 2'b00, 8'h40, 8'h66, 1);
    drive(0, 2'b01, 2'b00, 8'h40, 8'h66, 1);
    drive(1, 2'b01, 2'b00, 8'h41, 8'h66, 1);
    chk("rst pre out_data", 32'(out_data), 32'h40);
    drive(0, 2'b10, 2'b10, 8'h41, 8'h66, 1);
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst out_last",  32'(out_last),  32'd0);
    chk("rst out_data",  32'(out_data),  32'd0);
    chk("rst out_sel",   32'(out_sel),   32'd0);
    chk("rst in_ready",  32'(in_ready),  32'd0);
    chk("rst busy",      32'(busy),      32'd0);
    drive(0, 2'b10, 2'b10, 8'h41, 8'h66, 1);
    chk("post-rst busy",     32'(busy),      32'd1);
    chk("post-rst in_ready", 32'(in_ready),  32'b10);
    chk("post-rst out_valid", 32'(out_valid), 32'd0);
    drive(0, 2'b00, 2'b00, 8'h41, 8'h66, 1);
    chk("post-rst beat valid", 32'(out_valid), 32'd1);
    chk("post-rst beat data",  32'(out_data),  32'h66);
    chk("post-rst beat sel",   32'(out_sel),   32'd1);
    chk("post-rst beat last",  32'(out_last),  32'd1);
    chk("post-rst idle busy",  32'(busy),      32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_mux2_rr_arbiter
